// File: rtl/axusb_lcd_pkg.sv
// Shared definitions for the HD44780 character LCD transmitter.
// Holds FSM state codes, LCD command bytes, the power-on init ROM and
// small constant helpers used to size the delay counters.
package axusb_lcd_pkg;

    // Main FSM states
    localparam logic [2:0] ST_PWRON     = 3'd0;
    localparam logic [2:0] ST_INIT      = 3'd1;
    localparam logic [2:0] ST_ROW0_ADDR = 3'd2;
    localparam logic [2:0] ST_ROW0_CHR  = 3'd3;
    localparam logic [2:0] ST_ROW1_ADDR = 3'd4;
    localparam logic [2:0] ST_ROW1_CHR  = 3'd5;

    // HD44780 command bytes
    localparam logic [7:0] LCD_FSET  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_ON    = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_CLR   = 8'h01;  // clear display
    localparam logic [7:0] LCD_ENTRY = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_ROW0  = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LCD_ROW1  = 8'hC0;  // DDRAM address 0x40

    typedef struct packed {
        logic       long_wait;
        logic [7:0] code;
    } init_entry_t;

    localparam int INIT_LEN = 7;

    // Power-on sequence; the first function-set and the clear need the long wait
    localparam init_entry_t [0:INIT_LEN-1] INIT_ROM = {
        {1'b1, LCD_FSET},
        {1'b0, LCD_FSET},
        {1'b0, LCD_FSET},
        {1'b0, LCD_FSET},
        {1'b0, LCD_ON},
        {1'b1, LCD_CLR},
        {1'b0, LCD_ENTRY}
    };

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width able to hold 0 .. max_delay-1; terminal counts reload before wrap
    function automatic int cnt_width(input int max_delay);
        return (max_delay > 1) ? $clog2(max_delay) : 1;
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Purpose: drives one HD44780 write cycle (SETUP, E pulse, HOLD, WAIT) on RS/DB/E.
// Latency: pins update the cycle after start; done pulses in the last WAIT cycle.
// Backpressure: none; start may coincide with done for gap-free back-to-back bytes.
import axusb_lcd_pkg::*;

module lcd_byte_tx #(
    parameter int T_LONG = 131_200,
    parameter int T_CMD  = 1_600,
    parameter int E_PW   = 16,
    parameter int T_SU   = 2
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_rs,
    output logic [7:0] lcd_db,
    output logic       lcd_e
);

    localparam int CW = cnt_width(max2(T_LONG, max2(T_CMD, max2(E_PW, T_SU))));

    localparam logic [CW-1:0] SU_LAST   = CW'(T_SU - 1);
    localparam logic [CW-1:0] EPW_LAST  = CW'(E_PW - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(T_LONG - 1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(T_CMD - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_EHIGH = 2'd1;
    localparam logic [1:0] PH_HOLD  = 2'd2;
    localparam logic [1:0] PH_WAIT  = 2'd3;

    logic          busy_q, busy_d;
    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          long_q, long_d;
    logic          rs_q, rs_d;
    logic [7:0]    db_q, db_d;
    logic          e_q, e_d;
    logic [CW-1:0] phase_last;
    logic          phase_end;

    // Terminal count of the phase currently running
    always_comb begin
        phase_last = CMD_LAST;
        case (phase_q)
            PH_SETUP: phase_last = SU_LAST;
            PH_EHIGH: phase_last = EPW_LAST;
            PH_HOLD:  phase_last = SU_LAST;
            default:  phase_last = long_q ? LONG_LAST : CMD_LAST;
        endcase
    end

    assign phase_end = busy_q && (cnt_q == phase_last);
    assign done      = phase_end && (phase_q == PH_WAIT);

    // Phase sequencing; RS/DB are captured only when a byte is launched
    always_comb begin
        busy_d  = busy_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        long_d  = long_q;
        rs_d    = rs_q;
        db_d    = db_q;
        e_d     = e_q;
        if (start) begin
            busy_d  = 1'b1;
            phase_d = PH_SETUP;
            cnt_d   = '0;
            long_d  = long_wait;
            rs_d    = rs;
            db_d    = data;
            e_d     = 1'b0;
        end else if (busy_q) begin
            if (phase_end) begin
                cnt_d = '0;
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_EHIGH;
                        e_d     = 1'b1;
                    end
                    PH_EHIGH: begin
                        phase_d = PH_HOLD;
                        e_d     = 1'b0;
                    end
                    PH_HOLD:  phase_d = PH_WAIT;
                    default:  busy_d  = 1'b0;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Phase state and pin registers; reset drops every pin low at once
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            phase_q <= PH_SETUP;
            cnt_q   <= '0;
            long_q  <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            e_q     <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            long_q  <= long_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
        end
    end

    assign lcd_rs = rs_q;
    assign lcd_db = db_q;
    assign lcd_e  = e_q;

endmodule

// File: rtl/lcd_ctrl.sv
// Purpose: 16x2 HD44780 driver; power-on init, then endless refresh from a 32-byte shadow buffer.
// Latency: buffer writes land on the next edge; a slot is sampled when its byte is launched.
// Backpressure: none; buffer writes are always accepted, fixed delays pace the panel.
import axusb_lcd_pkg::*;

module lcd_ctrl #(
    parameter int T_PWRON = 1_600_000,
    parameter int T_LONG  = 131_200,
    parameter int T_CMD   = 1_600,
    parameter int E_PW    = 16,
    parameter int T_SU    = 2
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        buf_we,
    input  logic [4:0]  buf_addr,
    input  logic [7:0]  buf_data,
    output logic        ready,
    output logic        frame_done,
    output logic [10:0] ax_lcd
);

    localparam int CW = cnt_width(max2(T_PWRON,
                                  max2(T_LONG, max2(T_CMD, max2(E_PW, T_SU)))));

    localparam logic [CW-1:0] PWR_LAST  = CW'(T_PWRON - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [4:0]    INIT_LAST = 5'(INIT_LEN - 1);

    logic [7:0]    shadow_q [32];
    logic [2:0]    state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [CW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic          ready_q, ready_d;
    logic          frame_done_q, frame_done_d;

    logic          launch;
    logic          tx_rs;
    logic [7:0]    tx_data;
    logic          tx_long;
    logic          tx_done;
    logic          lcd_rs;
    logic [7:0]    lcd_db;
    logic          lcd_e;

    // Shadow character buffer, writable in every state
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                shadow_q[i] <= 8'h20;
            end
        end else if (buf_we) begin
            shadow_q[buf_addr] <= buf_data;
        end
    end

    // Sequencer: (state, idx) names the byte in flight; the next one launches on done
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pwr_cnt_d    = pwr_cnt_q;
        ready_d      = ready_q;
        frame_done_d = 1'b0;
        launch       = 1'b0;
        case (state_q)
            ST_PWRON: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    pwr_cnt_d = '0;
                    state_d   = ST_INIT;
                    idx_d     = 5'd0;
                    launch    = 1'b1;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + CNT_ONE;
                end
            end
            ST_INIT: begin
                if (tx_done) begin
                    launch = 1'b1;
                    if (idx_q == INIT_LAST) begin
                        state_d = ST_ROW0_ADDR;
                        idx_d   = 5'd0;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_ROW0_ADDR: begin
                if (tx_done) begin
                    launch  = 1'b1;
                    state_d = ST_ROW0_CHR;
                    idx_d   = 5'd0;
                end
            end
            ST_ROW0_CHR: begin
                if (tx_done) begin
                    launch = 1'b1;
                    if (idx_q == 5'd15) begin
                        state_d = ST_ROW1_ADDR;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_ROW1_ADDR: begin
                if (tx_done) begin
                    launch  = 1'b1;
                    state_d = ST_ROW1_CHR;
                    idx_d   = 5'd16;
                end
            end
            ST_ROW1_CHR: begin
                if (tx_done) begin
                    launch = 1'b1;
                    if (idx_q == 5'd31) begin
                        state_d      = ST_ROW0_ADDR;
                        idx_d        = 5'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_PWRON;
                idx_d   = 5'd0;
            end
        endcase
    end

    // Byte for the upcoming (state, idx); character slots are read on the launch edge
    always_comb begin
        tx_rs   = 1'b0;
        tx_data = 8'h00;
        tx_long = 1'b0;
        case (state_d)
            ST_INIT: begin
                tx_data = INIT_ROM[idx_d[2:0]].code;
                tx_long = INIT_ROM[idx_d[2:0]].long_wait;
            end
            ST_ROW0_ADDR: tx_data = LCD_ROW0;
            ST_ROW1_ADDR: tx_data = LCD_ROW1;
            ST_ROW0_CHR, ST_ROW1_CHR: begin
                tx_rs   = 1'b1;
                tx_data = shadow_q[idx_d];
            end
            default: tx_data = 8'h00;
        endcase
    end

    // Sequencer registers and status flags
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_PWRON;
            idx_q        <= 5'd0;
            pwr_cnt_q    <= '0;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pwr_cnt_q    <= pwr_cnt_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    lcd_byte_tx #(
        .T_LONG (T_LONG),
        .T_CMD  (T_CMD),
        .E_PW   (E_PW),
        .T_SU   (T_SU)
    ) u_byte_tx (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .start     (launch),
        .rs        (tx_rs),
        .data      (tx_data),
        .long_wait (tx_long),
        .done      (tx_done),
        .lcd_rs    (lcd_rs),
        .lcd_db    (lcd_db),
        .lcd_e     (lcd_e)
    );

    // RW is tied low: the panel is written only, never read
    assign ax_lcd     = {lcd_e, 1'b0, lcd_rs, lcd_db};
    assign ready      = ready_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl with shortened delays: byte stream, timing, status flags, resets.
// Expected bytes and their E-fall times come from a timeline model of the protocol.
// Random buffer writes are logged with their edge index to predict each sampled slot.
module tb_lcd_ctrl;

    localparam int P_PWRON = 20;
    localparam int P_LONG  = 10;
    localparam int P_CMD   = 4;
    localparam int P_EPW   = 3;
    localparam int P_SU    = 1;

    localparam int B_CMD   = 2 * P_SU + P_EPW + P_CMD;
    localparam int B_LONG  = 2 * P_SU + P_EPW + P_LONG;
    localparam int FIRST_L = P_PWRON - 1;
    localparam int ROW0_L  = FIRST_L + 2 * B_LONG + 5 * B_CMD;
    localparam int FRAME   = 34 * B_CMD;
    localparam int E_FALL  = P_SU + P_EPW + 1;
    localparam int RACE_PE = ROW0_L + 6 * B_CMD;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        buf_we = 1'b0;
    logic [4:0]  buf_addr = 5'd0;
    logic [7:0]  buf_data = 8'd0;
    logic        ready;
    logic        frame_done;
    logic [10:0] ax_lcd;

    typedef struct {
        int         t;
        logic       rs;
        logic [7:0] db;
    } cap_t;

    typedef struct {
        int         w;
        int         a;
        logic [7:0] d;
    } wr_t;

    cap_t capq [$];
    wr_t  wq [$];
    int   pe;
    int   k;
    int   n_assert = 0;
    int   n_fail = 0;
    logic e_prev = 1'b0;

    lcd_ctrl #(
        .T_PWRON (P_PWRON),
        .T_LONG  (P_LONG),
        .T_CMD   (P_CMD),
        .E_PW    (P_EPW),
        .T_SU    (P_SU)
    ) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .ready      (ready),
        .frame_done (frame_done),
        .ax_lcd     (ax_lcd)
    );

    always #5 mclk = ~mclk;

    // Edge index since reset release: after the n-th rising edge pe == n
    always @(posedge mclk or negedge rst_n) begin
        if (!rst_n) pe <= 0;
        else        pe <= pe + 1;
    end

    // Capture RS/DB on every E falling edge
    always @(negedge mclk) begin
        cap_t c;
        if (!rst_n) begin
            e_prev = 1'b0;
        end else begin
            if (e_prev && !ax_lcd[10]) begin
                c.t  = pe;
                c.rs = ax_lcd[8];
                c.db = ax_lcd[7:0];
                capq.push_back(c);
            end
            e_prev = ax_lcd[10];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, assertions=%0d", n_assert);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Buffer content for slot s as seen by a launch on edge L
    function automatic logic [7:0] slot_at(input int s, input int L);
        logic [7:0] v = 8'h20;
        foreach (wq[i]) begin
            if (wq[i].a == s && wq[i].w < L) v = wq[i].d;
        end
        return v;
    endfunction

    // n-th byte after reset: launch edge, RS and DB
    function automatic void exp_byte(input int n, output int L, output logic rs, output logic [7:0] db);
        int j, f, b;
        rs = 1'b0;
        db = 8'h00;
        if (n < 7) begin
            L = FIRST_L;
            for (int i = 0; i < n; i++) L += (i == 0 || i == 5) ? B_LONG : B_CMD;
            case (n)
                4:       db = 8'h0C;
                5:       db = 8'h01;
                6:       db = 8'h06;
                default: db = 8'h38;
            endcase
        end else begin
            j = n - 7;
            f = j / 34;
            b = j % 34;
            L = ROW0_L + f * FRAME + b * B_CMD;
            if (b == 0)       db = 8'h80;
            else if (b == 17) db = 8'hC0;
            else begin
                rs = 1'b1;
                db = slot_at((b < 17) ? b - 1 : b - 2, L);
            end
        end
    endfunction

    function automatic int exp_count(input int upto);
        int n = 0;
        int L;
        logic rs;
        logic [7:0] db;
        exp_byte(n, L, rs, db);
        while (L + E_FALL <= upto) begin
            n++;
            exp_byte(n, L, rs, db);
        end
        return n;
    endfunction

    task automatic drain();
        cap_t c;
        int L;
        logic rs;
        logic [7:0] db;
        while (capq.size() > 0) begin
            c = capq.pop_front();
            exp_byte(k, L, rs, db);
            check($sformatf("byte%0d_time", k), c.t, L + E_FALL);
            check($sformatf("byte%0d_rs", k), {31'd0, c.rs}, {31'd0, rs});
            check($sformatf("byte%0d_db", k), {24'd0, c.db}, {24'd0, db});
            k++;
        end
    endtask

    task automatic cycle_checks();
        logic fd_exp;
        fd_exp = (pe - 1 - ROW0_L >= FRAME) && ((pe - 1 - ROW0_L) % FRAME == 0);
        check("rw_low", {31'd0, ax_lcd[9]}, 32'd0);
        if (pe < P_PWRON) check("pwron_quiet", {21'd0, ax_lcd}, 32'd0);
        check("ready", {31'd0, ready}, {31'd0, pe > ROW0_L});
        check("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_t w;
        buf_we   = 1'b1;
        buf_addr = 5'(a);
        buf_data = d;
        w.w = pe;
        w.a = a;
        w.d = d;
        wq.push_back(w);
    endtask

    task automatic run(input int ncyc, input bit directed, input bit rnd);
        int a;
        for (int c = 0; c < ncyc; c++) begin
            cycle_checks();
            drain();
            buf_we = 1'b0;
            if (directed && pe == 30)           wr(0, 8'h31);
            else if (directed && pe == 40)      wr(31, 8'h39);
            else if (directed && pe == RACE_PE) wr(5, 8'h41);
            else if (rnd && $urandom_range(0, 7) == 0) begin
                a = $urandom_range(1, 29);
                if (a >= 5) a++;
                wr(a, 8'($urandom_range(0, 255)));
            end
            @(negedge mclk);
        end
        buf_we = 1'b0;
        #1;
        drain();
        check("byte_count", k, exp_count(pe));
    endtask

    initial begin
        bit found;
        k = 0;
        repeat (3) @(negedge mclk);
        check("rst_ax_lcd", {21'd0, ax_lcd}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // Power-on, init, three frames with directed and random buffer writes
        rst_n = 1'b1;
        run(ROW0_L + 3 * FRAME + 10, 1'b1, 1'b1);

        // Reset in the middle of an E pulse
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge mclk);
            if (ax_lcd[10]) found = 1'b1;
        end
        check("e_high_found", {31'd0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ax_lcd", {21'd0, ax_lcd}, 32'd0);
        check("arst_ready", {31'd0, ready}, 32'd0);
        check("arst_frame_done", {31'd0, frame_done}, 32'd0);
        repeat (3) @(negedge mclk);
        capq.delete();
        wq.delete();
        k = 0;

        // Full init again, then a frame of spaces from the cleared buffer
        rst_n = 1'b1;
        run(ROW0_L + FRAME + 10, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
